// File: rtl/instr_memory_loadable.sv
// Run-time loadable instruction memory: bytes stream in LSB-first during LOAD; fetch reads have 1-cycle latency.
// Backpressure: fetch_ready drops for the whole load, and fetches made while it is low are dropped, not queued.
module instr_memory_loadable #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  addr_fault
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BIDX_W-1:0]   LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [MEM_AW-1:0]   LAST_WORD = MEM_AW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [MEM_AW-1:0]     ptr;
  logic [BIDX_W-1:0]     byte_idx;
  logic                  start_load;
  logic                  accept;
  logic                  wr_en;
  logic                  done_nxt;
  logic                  fetch_fire;
  logic                  in_range;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Abort (load_start) takes priority over a byte arriving in the same cycle.
  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    accept     = 1'b0;
    wr_en      = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (load_start) begin
          state_nxt  = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        if (load_start) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end else if (load_valid) begin
          accept = 1'b1;
          if (byte_idx == LAST_BYTE) begin
            wr_en = 1'b1;
            if (ptr == LAST_WORD) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    wr_word                   = asm_word;
    wr_word[DATA_WIDTH-8 +: 8] = load_byte;
  end

  assign load_busy   = (state == LOAD);
  assign fetch_ready = (state == RUN);
  assign fetch_fire  = fetch_req & fetch_ready;
  assign in_range    = ({1'b0, fetch_addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
      asm_word    <= '0;
      ptr         <= '0;
      byte_idx    <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      load_done <= done_nxt;
      if (start_load) begin
        asm_word   <= '0;
        ptr        <= '0;
        byte_idx   <= '0;
        load_count <= '0;
      end else if (accept) begin
        if (wr_en) begin
          mem[ptr]   <= wr_word;
          ptr        <= ptr + 1'b1;
          load_count <= load_count + 1'b1;
          byte_idx   <= '0;
          asm_word   <= '0;
        end else begin
          asm_word[8*byte_idx +: 8] <= load_byte;
          byte_idx                  <= byte_idx + 1'b1;
        end
      end
      instr_valid <= fetch_fire;
      addr_fault  <= fetch_fire & ~in_range;
      if (fetch_fire) instr <= in_range ? mem[fetch_addr[MEM_AW-1:0]] : NOP_WORD;
    end
  end

endmodule

// File: tb/tb_instr_memory_loadable.sv
// Directed bench: a DEPTH=32 instance for the general tests and a DEPTH=4 instance for the full-load case.
module tb_instr_memory_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  load_byte;
  logic [7:0]  fetch_addr;
  logic        fetch_req;
  logic        ls_a, lv_a, ls_b, lv_b;

  logic        busy_a, done_a, rdy_a, ivld_a, flt_a;
  logic [8:0]  cnt_a;
  logic [31:0] instr_a;
  logic        busy_b, done_b, rdy_b, ivld_b, flt_b;
  logic [8:0]  cnt_b;
  logic [31:0] instr_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_memory_loadable #(.ADDR_WIDTH(8), .DEPTH(32), .DATA_WIDTH(32), .NOP_WORD(32'h0)) dut_a (
    .clk(clk), .reset(reset), .load_start(ls_a), .load_byte(load_byte), .load_valid(lv_a),
    .load_busy(busy_a), .load_done(done_a), .load_count(cnt_a),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(rdy_a),
    .instr(instr_a), .instr_valid(ivld_a), .addr_fault(flt_a));

  instr_memory_loadable #(.ADDR_WIDTH(8), .DEPTH(4), .DATA_WIDTH(32), .NOP_WORD(32'h0)) dut_b (
    .clk(clk), .reset(reset), .load_start(ls_b), .load_byte(load_byte), .load_valid(lv_b),
    .load_busy(busy_b), .load_done(done_b), .load_count(cnt_b),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(rdy_b),
    .instr(instr_b), .instr_valid(ivld_b), .addr_fault(flt_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit to_b, input logic [7:0] b);
    load_byte = b;
    if (to_b) lv_b = 1'b1; else lv_a = 1'b1;
    tick();
    lv_a = 1'b0;
    lv_b = 1'b0;
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) ls_b = 1'b1; else ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    ls_b = 1'b0;
  endtask

  task automatic fetch(input bit use_b, input string tag, input logic [7:0] addr,
                       input logic [31:0] exp, input logic exp_flt);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    check({tag, ".instr"}, use_b ? instr_b : instr_a, exp);
    check({tag, ".valid"}, {31'b0, use_b ? ivld_b : ivld_a}, 32'd1);
    check({tag, ".fault"}, {31'b0, use_b ? flt_b : flt_a}, {31'b0, exp_flt});
  endtask

  initial begin
    reset = 1'b1; load_byte = '0; fetch_addr = '0; fetch_req = 1'b0;
    ls_a = 1'b0; lv_a = 1'b0; ls_b = 1'b0; lv_b = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state and fetches of the cleared memory
    check("rst.instr", instr_a, 32'h0);
    check("rst.valid", {31'b0, ivld_a}, 32'd0);
    check("rst.fault", {31'b0, flt_a}, 32'd0);
    check("rst.busy", {31'b0, busy_a}, 32'd0);
    check("rst.done", {31'b0, done_a}, 32'd0);
    check("rst.count", {23'b0, cnt_a}, 32'd0);
    check("rst.ready", {31'b0, rdy_a}, 32'd1);
    for (int i = 0; i < 4; i++) fetch(1'b0, $sformatf("t1.f%0d", i), 8'(i), 32'h0, 1'b0);

    // 2: two words then abort
    pulse_start(1'b0);
    check("t2.busy", {31'b0, busy_a}, 32'd1);
    check("t2.ready", {31'b0, rdy_a}, 32'd0);
    send_byte(1'b0, 8'h03); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h09); send_byte(1'b0, 8'h00); send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h20);
    check("t2.count_pre", {23'b0, cnt_a}, 32'd2);
    ls_a = 1'b1; lv_a = 1'b1; load_byte = 8'h77;  // abort beats the simultaneous byte
    tick();
    ls_a = 1'b0; lv_a = 1'b0;
    check("t2.done", {31'b0, done_a}, 32'd1);
    check("t2.busy_off", {31'b0, busy_a}, 32'd0);
    check("t2.count", {23'b0, cnt_a}, 32'd2);
    tick();
    check("t2.done_once", {31'b0, done_a}, 32'd0);
    fetch(1'b0, "t2.f0", 8'd0, 32'h2001_0003, 1'b0);
    fetch(1'b0, "t2.f1", 8'd1, 32'h2002_0009, 1'b0);
    fetch(1'b0, "t2.f2", 8'd2, 32'h0, 1'b0);
    tick();
    check("t2.hold_instr", instr_a, 32'h0);
    check("t2.hold_valid", {31'b0, ivld_a}, 32'd0);

    // 3: full load of the DEPTH=4 instance with automatic exit
    pulse_start(1'b1);
    check("t3.busy", {31'b0, busy_b}, 32'd1);
    for (int w = 0; w < 4; w++) begin
      send_byte(1'b1, 8'(w)); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
      if (w == 3) check("t3.no_early_done", {31'b0, done_b}, 32'd0);
      send_byte(1'b1, 8'h10);
    end
    check("t3.done", {31'b0, done_b}, 32'd1);
    check("t3.busy_off", {31'b0, busy_b}, 32'd0);
    check("t3.count", {23'b0, cnt_b}, 32'd4);
    tick();
    check("t3.done_once", {31'b0, done_b}, 32'd0);
    check("t3.count_hold", {23'b0, cnt_b}, 32'd4);
    for (int i = 0; i < 4; i++)
      fetch(1'b1, $sformatf("t3.f%0d", i), 8'(i), 32'h1000_0000 + i, 1'b0);
    fetch(1'b1, "t3.f4", 8'd4, 32'h0, 1'b1);

    // 4: out-of-range fetch and the range boundary
    fetch(1'b0, "t4.f40", 8'd40, 32'h0, 1'b1);
    tick();
    check("t4.fault_once", {31'b0, flt_a}, 32'd0);
    check("t4.valid_once", {31'b0, ivld_a}, 32'd0);
    fetch(1'b0, "t4.f31", 8'd31, 32'h0, 1'b0);
    fetch(1'b0, "t4.f32", 8'd32, 32'h0, 1'b1);

    // 5: fetch blocked during LOAD; load_start together with a fetch in RUN
    pulse_start(1'b0);
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    fetch_req = 1'b0;
    check("t5.ready", {31'b0, rdy_a}, 32'd0);
    check("t5.no_valid", {31'b0, ivld_a}, 32'd0);
    tick();
    check("t5.no_queue", {31'b0, ivld_a}, 32'd0);
    pulse_start(1'b0);
    check("t5.abort_done", {31'b0, done_a}, 32'd1);
    check("t5.abort_count", {23'b0, cnt_a}, 32'd0);
    ls_a = 1'b1; fetch_req = 1'b1; fetch_addr = 8'd1;
    tick();
    ls_a = 1'b0; fetch_req = 1'b0;
    check("t5.old_word", instr_a, 32'h2002_0009);
    check("t5.old_valid", {31'b0, ivld_a}, 32'd1);
    check("t5.busy", {31'b0, busy_a}, 32'd1);
    pulse_start(1'b0);

    // 6: reset mid-load discards everything
    pulse_start(1'b0);
    for (int i = 0; i < 6; i++) send_byte(1'b0, 8'hA0 + 8'(i));
    check("t6.count_pre", {23'b0, cnt_a}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.busy", {31'b0, busy_a}, 32'd0);
    check("t6.count", {23'b0, cnt_a}, 32'd0);
    check("t6.ready", {31'b0, rdy_a}, 32'd1);
    for (int i = 0; i < 4; i++) fetch(1'b0, $sformatf("t6.f%0d", i), 8'(i), 32'h0, 1'b0);
    fetch(1'b1, "t6.b0", 8'd0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
